uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for the M10 SoC peripheral bus. It is the receive-side counterpart of the existing uart_tx_o path.
- Deserialises 8N1 frames (8E1 when parity is enabled) from the asynchronous uart_rx_i pin.
- Presents each received byte in a holding register with a valid/ack handshake toward the core.
- Flags framing, overrun and (optionally) parity errors.

Parameters:
CLKS_PER_BIT, 868, clk_i cycles per bit (100 MHz / 115200). Legal range 4..65535.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter. Derived; do not override.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous assert, active-low (0 = reset)
uart_rx_i  input  1  serial line, idle high, asynchronous to clk_i
rx_data_o  output  8  last accepted byte
rx_valid_o  output  1  holding register full; level signal
rx_ack_i  input  1  core consumed rx_data_o; 1-cycle pulse
frame_err_o  output  1  sticky: stop bit sampled 0
overrun_o  output  1  sticky: frame completed while rx_valid_o=1
parity_err_o  output  1  sticky: parity mismatch (tied 0 without the optional feature)
clr_err_i  input  1  clears all sticky error flags
busy_o  output  1  1 while the FSM is not in IDLE

Behaviour:
- Reset (rst_i=0, immediate): state=IDLE, counters=0, rx_data_o=8'h00, rx_valid_o=0, busy_o=0, all error flags=0. Both synchroniser flops reset to 1 (idle line).
- Input synchroniser: 2-flop chain; the FSM uses only the second flop (rx_s). This adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, PARITY (only when the optional feature is compiled in), STOP, WAIT_HIGH.
- IDLE:
  - rx_s=0 -> START, counter cleared.
- START:
  - At counter=CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - Sample 1: false start; return to IDLE with no flags.
  - Sample 0: go to DATA, counter cleared, bit index=0.
- DATA:
  - Sample every CLKS_PER_BIT cycles (counter=CLKS_PER_BIT-1), so each sample is at bit centre.
  - LSB first, shifted into an internal shift register.
  - After bit index 7 -> PARITY if enabled, else STOP.
- STOP: sample at bit centre.
  - Sample 1: frame good.
  - Sample 0: set frame_err_o, discard the byte, go to WAIT_HIGH.
- Good frame handling:
  - rx_valid_o=0, or rx_ack_i=1 in the same cycle: load rx_data_o and set rx_valid_o on the next edge.
  - Otherwise: set overrun_o; rx_data_o keeps the old byte and the new byte is dropped.
  - Then return to IDLE. The FSM re-arms half a bit early, which allows back-to-back frames.
- WAIT_HIGH: stay until rx_s=1, then IDLE. This stops a break condition from re-triggering a frame.
- Latency: rx_valid_o rises 1 cycle after the stop-bit centre sample, i.e. about 9.5 bit times + 3 cycles after the falling start edge.
- Handshake:
  - rx_ack_i with rx_valid_o=1 clears rx_valid_o next cycle.
  - rx_ack_i with rx_valid_o=0 is ignored.
- Sticky flags: cleared only by clr_err_i or reset. If clr_err_i and a set event occur in the same cycle, set wins.
- busy_o=1 in every state except IDLE.
- The counter is CNT_W bits and never wraps mid-bit; it is cleared at each sample point.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - PARITY state is inserted after data bit 7 and sampled at bit centre; even parity is expected.
  - Mismatch sets parity_err_o. The byte is still delivered and the frame is then 8E1 (11 bits).
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_err_o is driven constant 0.

Test Plan:
1. CLKS_PER_BIT=16. Send 0xA5 8N1, then pulse ack -> rx_valid_o=1, rx_data_o=8'hA5, no error flags; rx_valid_o=0 the cycle after ack.
2. 3-cycle low glitch on an idle line -> FSM returns to IDLE; rx_valid_o, frame_err_o and busy_o are 0 within 10 cycles.
3. Send 0x3C with stop bit held 0 for 2 bit times, then idle, then 0x11 -> frame_err_o=1, no valid from the first frame; 0x11 is received correctly afterwards.
4. Send 0x01 then 0x02 back-to-back with no ack -> rx_data_o=8'h01, overrun_o=1. Repeat with ack pulsed on the cycle the second frame completes -> rx_data_o=8'h02, rx_valid_o=1, overrun_o=0.
5. Drive rst_i=0 during data bit 4 of a frame -> all outputs return to reset values immediately. The next full frame, 0x7E, is received correctly.
6. With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> rx_data_o=8'h07, parity_err_o=1. Pulse clr_err_i -> parity_err_o=0. Send 0x07 with parity bit 1 -> no error.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser with a valid/ack holding register and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity mismatches.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  input  logic       clr_err_i,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             sync1_q, rx_s_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, frame_err_q, overrun_q;

  logic tick_full, stop_smp, stop_good, load, ovr_set, ferr_set;

  // Idle-high reset value keeps a held reset from looking like a start bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  assign tick_full = (cnt_q == FULL);
  assign stop_smp  = (state_q == STOP) && tick_full;
  assign stop_good = stop_smp && rx_s_q;
  assign ferr_set  = stop_smp && !rx_s_q;
  assign load      = stop_good && (!rx_valid_q || rx_ack_i);
  assign ovr_set   = stop_good && rx_valid_q && !rx_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            if (rx_s_q) state_q <= IDLE;
            else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        DATA: begin
          if (tick_full) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx_q == 3'd7) state_q <= PARITY;
`else
            if (bit_idx_q == 3'd7) state_q <= STOP;
`endif
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_full) begin
            cnt_q   <= '0;
            state_q <= STOP;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
`endif
        STOP: begin
          // Leaving at stop-bit centre re-arms half a bit early for back-to-back frames.
          if (tick_full) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? IDLE : WAIT_HIGH;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        WAIT_HIGH: begin
          cnt_q <= '0;
          if (rx_s_q) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Holding register and sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (load) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_ack_i) begin
        rx_valid_q <= 1'b0;
      end
      if (ferr_set)       frame_err_q <= 1'b1;
      else if (clr_err_i) frame_err_q <= 1'b0;
      if (ovr_set)        overrun_q   <= 1'b1;
      else if (clr_err_i) overrun_q   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, par_set;
  assign par_set = (state_q == PARITY) && tick_full && (rx_s_q ^ (^shift_q));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         parity_err_q <= 1'b0;
    else if (par_set)   parity_err_q <= 1'b1;
    else if (clr_err_i) parity_err_q <= 1'b0;
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of single frames plus corner-case sequences.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk_i = 1'b0;
  logic       rst_i, uart_rx_i, rx_ack_i, clr_err_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overrun_o, parity_err_o, busy_o;

  int errs = 0;
  int checks = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .uart_rx_i(uart_rx_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .parity_err_o(parity_err_o),
    .clr_err_i(clr_err_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bit_(input logic b);
    uart_rx_i = b;
    cyc(CPB);
  endtask

  // Start bit, data LSB first, and the parity bit when that build is selected.
  task automatic send_hdr(input logic [7:0] d, input logic bad_par);
    bit_(1'b0);
    for (int i = 0; i < 8; i++) bit_(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_((^d) ^ bad_par);
`else
    if (bad_par) bit_(1'b1);
`endif
  endtask

  // ack_at_stop raises rx_ack_i for exactly the stop-bit centre sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                            input logic ack_at_stop);
    send_hdr(d, bad_par);
    uart_rx_i = stop;
    if (ack_at_stop) begin
      cyc(10);
      rx_ack_i = 1'b1;
      cyc(1);
      rx_ack_i = 1'b0;
      cyc(5);
    end else cyc(CPB);
    uart_rx_i = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack_i = 1'b1;
    cyc(1);
    rx_ack_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1;
    cyc(1);
    clr_err_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0};

    rst_i = 1'b0; uart_rx_i = 1'b1; rx_ack_i = 1'b0; clr_err_i = 1'b0;
    cyc(3);
    chk("reset data", rx_data_o, 8'h00);
    chk("reset valid", rx_valid_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset ferr", frame_err_o, 0);
    chk("reset ovr", overrun_o, 0);
    chk("reset perr", parity_err_o, 0);
    rst_i = 1'b1;
    cyc(4);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].din, vecs[v].stop, 1'b0, 1'b0);
      chk($sformatf("vec%0d data", v), rx_data_o, vecs[v].exp_data);
      chk($sformatf("vec%0d valid", v), rx_valid_o, vecs[v].exp_valid);
      chk($sformatf("vec%0d ferr", v), frame_err_o, vecs[v].exp_ferr);
      chk($sformatf("vec%0d ovr", v), overrun_o, 0);
      chk($sformatf("vec%0d perr", v), parity_err_o, 0);
      pulse_ack();
      chk($sformatf("vec%0d valid after ack", v), rx_valid_o, 0);
      pulse_clr();
      chk($sformatf("vec%0d ferr after clr", v), frame_err_o, 0);
      cyc(4);
    end

    // Short low glitch is a false start.
    uart_rx_i = 1'b0;
    cyc(3);
    uart_rx_i = 1'b1;
    cyc(3);
    chk("glitch busy mid", busy_o, 1);
    cyc(7);
    chk("glitch busy end", busy_o, 0);
    chk("glitch valid", rx_valid_o, 0);
    chk("glitch ferr", frame_err_o, 0);

    // Stop bit held low for two bit times, then recovery.
    send_hdr(8'h3C, 1'b0);
    bit_(1'b0);
    bit_(1'b0);
    chk("break busy in wait_high", busy_o, 1);
    bit_(1'b1);
    bit_(1'b1);
    chk("break ferr", frame_err_o, 1);
    chk("break valid", rx_valid_o, 0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("recover data", rx_data_o, 8'h11);
    chk("recover valid", rx_valid_o, 1);
    chk("recover ferr sticky", frame_err_o, 1);
    pulse_ack();
    pulse_clr();
    cyc(4);

    // Back-to-back with no ack: overrun, old byte kept.
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    chk("ovr data", rx_data_o, 8'h01);
    chk("ovr valid", rx_valid_o, 1);
    chk("ovr flag", overrun_o, 1);
    pulse_ack();
    pulse_clr();
    chk("ovr cleared", overrun_o, 0);
    cyc(4);

    // Ack coincident with completion: new byte loads, no overrun.
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0, 1'b1);
    chk("ack-at-stop data", rx_data_o, 8'h02);
    chk("ack-at-stop valid", rx_valid_o, 1);
    chk("ack-at-stop ovr", overrun_o, 0);
    pulse_ack();
    cyc(4);

    // Reset asserted mid data bit 4.
    bit_(1'b0);
    for (int i = 0; i < 4; i++) bit_(1'b1);
    uart_rx_i = 1'b0;
    cyc(8);
    chk("pre-reset busy", busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk("async rst data", rx_data_o, 8'h00);
    chk("async rst busy", busy_o, 0);
    chk("async rst valid", rx_valid_o, 0);
    uart_rx_i = 1'b1;
    cyc(4);
    rst_i = 1'b1;
    cyc(20);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    chk("post-rst data", rx_data_o, 8'h7E);
    chk("post-rst valid", rx_valid_o, 1);
    chk("post-rst ferr", frame_err_o, 0);
    pulse_ack();
    cyc(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par bad data", rx_data_o, 8'h07);
    chk("par bad flag", parity_err_o, 1);
    pulse_ack();
    pulse_clr();
    chk("par cleared", parity_err_o, 0);
    cyc(4);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    chk("par good data", rx_data_o, 8'h07);
    chk("par good flag", parity_err_o, 0);
    chk("par good valid", rx_valid_o, 1);
    pulse_ack();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
